// File: rtl/seg_register_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_register_file_pkg
//  Brief    : Shared widths, dump FSM encoding and read-mux helper for the
//             MIPS architectural register file.
//  Revision : 1.0 - initial release
// ============================================================================
package seg_register_file_pkg;

  localparam int NB_REG  = 32;            // data width of each register
  localparam int NB_ADDR = 5;             // register address width
  localparam int N_REGS  = 2 ** NB_ADDR;  // number of registers

  localparam logic [NB_ADDR-1:0] REG_ZERO = '0;  // hardwired-zero register

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DUMP = 2'b01,
    ST_DONE = 2'b10
  } dump_state_t;

  // Value seen by any read port: r0 is always zero, an in-flight write to the
  // same address wins over the stored copy, otherwise the array contents.
  function automatic logic [NB_REG-1:0] f_read_mux(
    input logic [NB_ADDR-1:0] addr,
    input logic [NB_REG-1:0]  stored,
    input logic               we,
    input logic [NB_ADDR-1:0] waddr,
    input logic [NB_REG-1:0]  wdata
  );
    logic [NB_REG-1:0] v;
    if (addr == REG_ZERO) begin
      v = '0;
    end else if (we && (waddr == addr)) begin
      v = wdata;
    end else begin
      v = stored;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_register_file_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg_register_file_if
//  Brief    : Pipeline read/write and debug dump signals of the register file.
//             slave = register file side, master = pipeline / debug side.
//  Revision : 1.0 - initial release
// ============================================================================
interface seg_register_file_if;

  // ID-stage read ports
  logic [seg_register_file_pkg::NB_ADDR-1:0] i_read_reg1;
  logic [seg_register_file_pkg::NB_ADDR-1:0] i_read_reg2;
  logic [seg_register_file_pkg::NB_REG-1:0]  o_read_data1;
  logic [seg_register_file_pkg::NB_REG-1:0]  o_read_data2;

  // WB-stage write port
  logic                                      i_RegWrite;
  logic [seg_register_file_pkg::NB_ADDR-1:0] i_write_reg;
  logic [seg_register_file_pkg::NB_REG-1:0]  i_write_data;

  // Debug dump stream
  logic                                      i_dump_start;
  logic                                      i_dump_ready;
  logic                                      o_dump_valid;
  logic [seg_register_file_pkg::NB_ADDR-1:0] o_dump_addr;
  logic [seg_register_file_pkg::NB_REG-1:0]  o_dump_data;
  logic                                      o_dump_done;
  logic                                      o_dump_busy;

  modport slave (
    input  i_read_reg1, i_read_reg2, i_RegWrite, i_write_reg, i_write_data,
           i_dump_start, i_dump_ready,
    output o_read_data1, o_read_data2, o_dump_valid, o_dump_addr, o_dump_data,
           o_dump_done, o_dump_busy
  );

  modport master (
    output i_read_reg1, i_read_reg2, i_RegWrite, i_write_reg, i_write_data,
           i_dump_start, i_dump_ready,
    input  o_read_data1, o_read_data2, o_dump_valid, o_dump_addr, o_dump_data,
           o_dump_done, o_dump_busy
  );

endinterface
`default_nettype wire

// File: rtl/seg_register_file_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_register_file_dump_ctrl
//  Brief    : Dump sequencer: walks the register index 0..N_REGS-1 over a
//             valid/ready handshake and pulses done after the last transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_register_file_dump_ctrl
  import seg_register_file_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  output logic               o_dump_valid,
  output logic [NB_ADDR-1:0] o_dump_addr,
  output logic               o_dump_done,
  output logic               o_dump_busy
);

  localparam logic [NB_ADDR-1:0] C_LAST_IDX = NB_ADDR'(N_REGS - 1);

  dump_state_t        r_state;
  dump_state_t        w_state_next;
  logic [NB_ADDR-1:0] r_index;
  logic [NB_ADDR-1:0] w_index_next;

  // State and index registers; reset abandons any dump in progress.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_index <= '0;
    end else begin
      r_state <= w_state_next;
      r_index <= w_index_next;
    end
  end

  // Next state, index advance on each accepted word, and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    o_dump_valid = 1'b0;
    o_dump_done  = 1'b0;
    o_dump_busy  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_dump_start) begin
          w_state_next = ST_DUMP;
          w_index_next = '0;
        end
      end
      ST_DUMP: begin
        o_dump_valid = 1'b1;
        o_dump_busy  = 1'b1;
        if (i_dump_ready) begin
          // The last index leaves DUMP before it could wrap back to zero.
          if (r_index == C_LAST_IDX) begin
            w_state_next = ST_DONE;
          end else begin
            w_index_next = r_index + NB_ADDR'(1);
          end
        end
      end
      ST_DONE: begin
        o_dump_done  = 1'b1;
        o_dump_busy  = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_dump_addr = r_index;

endmodule
`default_nettype wire

// File: rtl/seg_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : seg_register_file
//  Brief    : MIPS architectural register file: two combinational read ports
//             with same-cycle write bypass, one synchronous write port, r0
//             hardwired to zero, and a handshaked debug dump of all registers.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_register_file
  import seg_register_file_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  seg_register_file_if.slave bus
);

  logic [NB_REG-1:0]  r_regs [N_REGS];
  logic               w_we;
  logic [NB_ADDR-1:0] w_dump_addr;

  // Effective write: r0 writes are dropped and reset suppresses the bypass.
  assign w_we = bus.i_RegWrite && (bus.i_write_reg != REG_ZERO) && !i_rst;

  // Storage array; the dump engine only reads it, so pipeline writes never stall.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[bus.i_write_reg] <= bus.i_write_data;
    end
  end

  assign bus.o_read_data1 = f_read_mux(bus.i_read_reg1, r_regs[bus.i_read_reg1],
                                       w_we, bus.i_write_reg, bus.i_write_data);
  assign bus.o_read_data2 = f_read_mux(bus.i_read_reg2, r_regs[bus.i_read_reg2],
                                       w_we, bus.i_write_reg, bus.i_write_data);

  seg_register_file_dump_ctrl u_dump_ctrl (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_dump_start (bus.i_dump_start),
    .i_dump_ready (bus.i_dump_ready),
    .o_dump_valid (bus.o_dump_valid),
    .o_dump_addr  (w_dump_addr),
    .o_dump_done  (bus.o_dump_done),
    .o_dump_busy  (bus.o_dump_busy)
  );

  // The dump word follows the same bypass rule so a concurrent write is visible.
  assign bus.o_dump_addr = w_dump_addr;
  assign bus.o_dump_data = f_read_mux(w_dump_addr, r_regs[w_dump_addr],
                                      w_we, bus.i_write_reg, bus.i_write_data);

endmodule
`default_nettype wire

// File: tb/tb_seg_register_file.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_seg_register_file
//  Brief    : Self-checking bench for seg_register_file against an array model
//             of the architectural registers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_register_file;
  import seg_register_file_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_register_file_if bus();

  seg_register_file dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [32];

  // Expected read value from the model plus the same-cycle write bypass rule.
  function automatic logic [31:0] exp_read(input int addr);
    if (addr == 0) return 32'h0;
    if (!rst && bus.i_RegWrite && int'(bus.i_write_reg) == addr) return bus.i_write_data;
    return model[addr];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic idle_inputs();
    bus.i_read_reg1  = '0;
    bus.i_read_reg2  = '0;
    bus.i_RegWrite   = 1'b0;
    bus.i_write_reg  = '0;
    bus.i_write_data = '0;
    bus.i_dump_start = 1'b0;
    bus.i_dump_ready = 1'b0;
  endtask

  // Advance one clock, committing the pending write into the model.
  task automatic step();
    logic        we;
    int          wa;
    logic [31:0] wd;
    we = bus.i_RegWrite && !rst;
    wa = int'(bus.i_write_reg);
    wd = bus.i_write_data;
    @(posedge clk);
    if (we && wa != 0) model[wa] = wd;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    clear_model();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.i_RegWrite   = 1'b1;
    bus.i_write_reg  = 5'd5;
    bus.i_write_data = 32'hAAAA_5555;
    bus.i_read_reg1  = 5'd5;
    bus.i_read_reg2  = 5'd31;
    #1;
    n_cmp++;
    if (bus.o_read_data1 !== 32'h0) begin
      n_err++; $display("FAIL reset_rd1: got %h expected 00000000", bus.o_read_data1);
    end
    n_cmp++;
    if (bus.o_read_data2 !== 32'h0) begin
      n_err++; $display("FAIL reset_rd2: got %h expected 00000000", bus.o_read_data2);
    end
    n_cmp++;
    if ({bus.o_dump_valid, bus.o_dump_busy, bus.o_dump_done} !== 3'b000) begin
      n_err++; $display("FAIL reset_dump_flags: got %b expected 000",
                        {bus.o_dump_valid, bus.o_dump_busy, bus.o_dump_done});
    end
    n_cmp++;
    if (bus.o_dump_addr !== 5'd0) begin
      n_err++; $display("FAIL reset_dump_addr: got %0d expected 0", bus.o_dump_addr);
    end
    idle_inputs();
    #2 rst = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    bus.i_RegWrite   = 1'b1;
    bus.i_write_reg  = 5'd5;
    bus.i_write_data = 32'hDEAD_BEEF;
    step();
    bus.i_RegWrite  = 1'b0;
    bus.i_read_reg1 = 5'd5;
    #1;
    n_cmp++;
    if (bus.o_read_data1 !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL write_read_r5: got %h expected deadbeef", bus.o_read_data1);
    end
    step();
  endtask

  task automatic test_bypass();
    bus.i_RegWrite   = 1'b1;
    bus.i_write_reg  = 5'd7;
    bus.i_write_data = 32'h1234_5678;
    bus.i_read_reg2  = 5'd7;
    #1;
    n_cmp++;
    if (bus.o_read_data2 !== 32'h1234_5678) begin
      n_err++; $display("FAIL bypass_r7: got %h expected 12345678", bus.o_read_data2);
    end
    step();
    bus.i_RegWrite = 1'b0;
    #1;
    n_cmp++;
    if (bus.o_read_data2 !== 32'h1234_5678) begin
      n_err++; $display("FAIL stored_r7: got %h expected 12345678", bus.o_read_data2);
    end
    step();
  endtask

  task automatic test_r0();
    bus.i_RegWrite   = 1'b1;
    bus.i_write_reg  = 5'd0;
    bus.i_write_data = 32'hFFFF_FFFF;
    bus.i_read_reg1  = 5'd0;
    bus.i_read_reg2  = 5'd0;
    #1;
    n_cmp++;
    if (bus.o_read_data1 !== 32'h0 || bus.o_read_data2 !== 32'h0) begin
      n_err++; $display("FAIL r0_same_cycle: got %h/%h expected 0/0",
                        bus.o_read_data1, bus.o_read_data2);
    end
    step();
    bus.i_RegWrite = 1'b0;
    #1;
    n_cmp++;
    if (bus.o_read_data1 !== 32'h0) begin
      n_err++; $display("FAIL r0_next_cycle: got %h expected 00000000", bus.o_read_data1);
    end
    step();
  endtask

  task automatic test_random_rw();
    for (int k = 0; k < 300; k++) begin
      bus.i_RegWrite   = 1'($urandom_range(0, 1));
      bus.i_write_reg  = 5'($urandom);
      bus.i_write_data = $urandom;
      bus.i_read_reg1  = ($urandom_range(0, 3) == 0) ? bus.i_write_reg : 5'($urandom);
      bus.i_read_reg2  = 5'($urandom);
      #1;
      n_cmp++;
      if (bus.o_read_data1 !== exp_read(int'(bus.i_read_reg1))) begin
        n_err++; $display("FAIL rand_rd1 r%0d: got %h expected %h", bus.i_read_reg1,
                          bus.o_read_data1, exp_read(int'(bus.i_read_reg1)));
      end
      n_cmp++;
      if (bus.o_read_data2 !== exp_read(int'(bus.i_read_reg2))) begin
        n_err++; $display("FAIL rand_rd2 r%0d: got %h expected %h", bus.i_read_reg2,
                          bus.o_read_data2, exp_read(int'(bus.i_read_reg2)));
      end
      step();
    end
    idle_inputs();
  endtask

  // Run one full dump; the model tracks which index the consumer must see next.
  task automatic run_dump(input bit rand_ready, input bit rand_writes, output int cycles);
    int exp_idx;
    exp_idx = 0;
    cycles  = 0;
    idle_inputs();
    bus.i_dump_start = 1'b1;
    step();
    bus.i_dump_start = 1'b0;
    while (exp_idx < 32 && cycles < 1000) begin
      bus.i_dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rand_writes) begin
        bus.i_RegWrite   = 1'($urandom_range(0, 1));
        bus.i_write_reg  = ($urandom_range(0, 2) == 0) ? 5'(exp_idx) : 5'($urandom);
        bus.i_write_data = $urandom;
      end
      #1;
      n_cmp++;
      if (bus.o_dump_valid !== 1'b1 || bus.o_dump_busy !== 1'b1 || bus.o_dump_done !== 1'b0) begin
        n_err++; $display("FAIL dump_flags idx %0d: valid/busy/done got %b%b%b expected 110",
                          exp_idx, bus.o_dump_valid, bus.o_dump_busy, bus.o_dump_done);
      end
      n_cmp++;
      if (bus.o_dump_addr !== 5'(exp_idx)) begin
        n_err++; $display("FAIL dump_addr: got %0d expected %0d", bus.o_dump_addr, exp_idx);
      end
      n_cmp++;
      if (bus.o_dump_data !== exp_read(exp_idx)) begin
        n_err++; $display("FAIL dump_data idx %0d: got %h expected %h",
                          exp_idx, bus.o_dump_data, exp_read(exp_idx));
      end
      if (bus.i_dump_ready) exp_idx++;
      step();
      cycles++;
    end
    n_cmp++;
    if (exp_idx != 32) begin
      n_err++; $display("FAIL dump_timeout: got %0d words expected 32", exp_idx);
    end
    idle_inputs();
    #1;
    n_cmp++;
    if ({bus.o_dump_valid, bus.o_dump_busy, bus.o_dump_done} !== 3'b011) begin
      n_err++; $display("FAIL dump_done_pulse: valid/busy/done got %b expected 011",
                        {bus.o_dump_valid, bus.o_dump_busy, bus.o_dump_done});
    end
    step();
    n_cmp++;
    if ({bus.o_dump_valid, bus.o_dump_busy, bus.o_dump_done} !== 3'b000) begin
      n_err++; $display("FAIL dump_after_done: valid/busy/done got %b expected 000",
                        {bus.o_dump_valid, bus.o_dump_busy, bus.o_dump_done});
    end
  endtask

  task automatic test_dump_full();
    int cycles;
    for (int i = 1; i < 32; i++) begin
      bus.i_RegWrite   = 1'b1;
      bus.i_write_reg  = 5'(i);
      bus.i_write_data = 32'(i * 4);
      step();
    end
    idle_inputs();
    run_dump(1'b0, 1'b0, cycles);
    n_cmp++;
    if (cycles != 32) begin
      n_err++; $display("FAIL dump_full_cycles: got %0d expected 32", cycles);
    end
    n_cmp++;
    if (model[31] !== 32'd124) begin
      n_err++; $display("FAIL dump_preload_r31: got %h expected 0000007c", model[31]);
    end
  endtask

  task automatic test_dump_toggle();
    int cycles;
    run_dump(1'b1, 1'b1, cycles);
  endtask

  task automatic test_reset_mid_dump();
    int cycles;
    idle_inputs();
    bus.i_dump_start = 1'b1;
    step();
    bus.i_dump_start = 1'b0;
    bus.i_dump_ready = 1'b1;
    repeat (10) step();
    n_cmp++;
    if (bus.o_dump_addr !== 5'd10) begin
      n_err++; $display("FAIL mid_dump_addr: got %0d expected 10", bus.o_dump_addr);
    end
    bus.i_read_reg1 = 5'd5;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.o_dump_valid, bus.o_dump_busy, bus.o_dump_done} !== 3'b000) begin
      n_err++; $display("FAIL mid_dump_reset_flags: got %b expected 000",
                        {bus.o_dump_valid, bus.o_dump_busy, bus.o_dump_done});
    end
    n_cmp++;
    if (bus.o_read_data1 !== 32'h0) begin
      n_err++; $display("FAIL mid_dump_reset_r5: got %h expected 00000000", bus.o_read_data1);
    end
    clear_model();
    #3 rst = 1'b0;
    bus.i_dump_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (bus.o_dump_done !== 1'b0 || bus.o_dump_valid !== 1'b0) begin
        n_err++; $display("FAIL post_reset_quiet: done/valid got %b%b expected 00",
                          bus.o_dump_done, bus.o_dump_valid);
      end
    end
    run_dump(1'b0, 1'b0, cycles);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_random_rw();
    test_dump_full();
    test_dump_toggle();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
